rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Registered, handshaked instruction-decode stage for the RV32I core. It is the multi-cycle and pipelined successor of the combinational field splitter.
- Accepts 32-bit instruction words from fetch over valid/ready and extracts all RV32I fields.
- Classifies the instruction format, generates the sign-extended immediate and flags illegal opcodes.
- Presents one registered decode bundle to execute over valid/ready, with optional skid buffering, flush and a decode counter.

Parameters:
- XLEN, 32: width of imm output; must be ≥32; sign extension fills bits above 31.
- SKID, 1: 1 = 1-entry skid buffer so in_ready is a pure register output; 0 = plain pipeline register with in_ready = !out_valid || out_ready.
- CNT_W, 16: width of the decoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops all held/in-flight instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  execute accepts.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_funct3  out  3  instr[14:12].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_funct7  out  7  instr[31:25].
- out_fmt  out  3  format code: R=0 I=1 S=2 B=3 U=4 J=5 ILL=7.
- out_imm  out  XLEN  sign-extended immediate; 0 for R and ILL.
- out_illegal  out  1  opcode is not RV32I.
- decode_cnt  out  CNT_W  count of bundles accepted by execute.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, in_ready=1.
  - All out_* fields 0, out_fmt=0.
  - decode_cnt=0.
  - Skid entry empty.
  - Reset mid-transfer discards everything.
- Decode is purely combinational on in_instr. Results are registered on the accept edge (in_valid && in_ready).
- Latency: 1 cycle from accept to out_valid.
- Opcode map:
  - 0110011 → R.
  - 0010011 / 0000011 / 1100111 / 1110011 / 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111 / 0010111 → U.
  - 1101111 → J.
  - Anything else → ILL with out_illegal=1.
  - An ILL bundle is still transferred, so execute can trap.
- Immediates, sign bit instr[31]:
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
- Output register:
  - Holds stable while out_valid && !out_ready. No field may change during a stall.
  - Loads on the next accepted input; otherwise out_valid falls after transfer.
- SKID=0: in_ready = !out_valid || out_ready (combinational). Simultaneous transfer-out and accept-in sustains 1 instr/cycle.
- SKID=1:
  - in_ready = !skid_full (registered).
  - If an instruction is accepted while the output is stalled, it is decoded into the skid entry.
  - When the output transfers, the skid entry moves to the output in the same edge.
  - Throughput stays 1/cycle, with no bubble on stall release.
  - Order is always preserved.
- Flush:
  - The cycle after flush is asserted: out_valid=0 and the skid entry is empty.
  - Any input accepted in the flush cycle is discarded.
  - in_ready=1 the cycle after.
  - Flush has priority over accept and transfer in the same cycle.
  - decode_cnt still counts a transfer that completes in the flush cycle.
- decode_cnt increments on out_valid && out_ready. It wraps modulo 2^CNT_W, all-ones → 0.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams.
  - the fmt enum/constants (R..J, ILL=7).
  - the decode-bundle struct (opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal).
- Sub-module rv_imm_gen: combinational instr → (fmt, imm, illegal), parametrised by XLEN. Instantiated once and feeding both the output and skid registers.

Test Plan:
- Decode R-type: in_instr 0x007302B3 (add x5,x6,x7) → 1 cycle later out_rd=5, out_rs1=6, out_rs2=7, out_funct3=0, out_funct7=0, out_opcode=0x33, out_fmt=0, out_imm=0, decode_cnt=1.
- Decode I, U, B back-to-back with out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFFFFFF, fmt=1.
  - 0x12345137 (lui x2,0x12345) → imm 0x12345000, fmt=4.
  - 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, fmt=3.
  - Three consecutive out_valid cycles.
- Stall with SKID=1: hold out_ready=0 with 2 instructions offered → second captured in skid, in_ready=0, output fields stable. Release → both delivered in order on consecutive cycles with no bubble.
- Illegal: 0x00000000 → out_illegal=1, out_fmt=7, out_imm=0, bundle still handshaken.
- Flush during stall (output + skid full) → next cycle out_valid=0, in_ready=1, neither instruction ever appears, decode_cnt unchanged.
- Reset asserted asynchronously mid-stream → outputs clear immediately, without waiting for a clock edge. Counter wrap with CNT_W=4: 16 transfers → decode_cnt=0.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32I opcodes, format codes and the decode bundle shared by the decode stage.
package rv_decode_pkg;

  localparam int IMM_W = 32;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    fmt_e             fmt;
    logic [IMM_W-1:0] imm;
    logic             illegal;
  } bundle_t;

  // Fixed-position fields only; fmt/imm/illegal are filled in from rv_imm_gen.
  function automatic bundle_t split_fields(input logic [31:0] instr);
    bundle_t b;
    b         = '0;
    b.opcode  = instr[6:0];
    b.rd      = instr[11:7];
    b.funct3  = instr[14:12];
    b.rs1     = instr[19:15];
    b.rs2     = instr[24:20];
    b.funct7  = instr[31:25];
    return b;
  endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - Fetch-side and execute-side handshakes of the decode stage.
interface rv_decode_stage_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
           out_rs2, out_funct7, out_fmt, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
           out_rs2, out_funct7, out_fmt, out_imm, out_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - Combinational RV32I format classifier and sign-extended immediate generator.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output fmt_e            o_fmt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);
  logic [31:0] w_imm32;

  always_comb begin
    o_fmt     = FMT_ILL;
    o_illegal = 1'b0;
    w_imm32   = '0;
    case (i_instr[6:0])
      OP_OP: o_fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - Registered RV32I decode stage with optional skid entry, flush and transfer counter.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  rv_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] decode_cnt
);
  bundle_t          w_new;
  fmt_e             w_fmt;
  logic [IMM_W-1:0] w_imm;
  logic             w_illegal;
  logic             w_accept;
  logic             w_xfer;
  logic             w_load_ok;

  bundle_t r_out;
  bundle_t r_skid;
  logic    r_out_valid;
  logic    r_skid_valid;
  logic    r_in_ready;

  // The bundle keeps the 32-bit architectural immediate; widening to XLEN happens at the port.
  rv_imm_gen #(.XLEN(IMM_W)) u_imm_gen (
    .i_instr   (bus.in_instr),
    .o_fmt     (w_fmt),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_new         = split_fields(bus.in_instr);
    w_new.fmt     = w_fmt;
    w_new.imm     = w_imm;
    w_new.illegal = w_illegal;
  end

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_xfer    = r_out_valid && bus.out_ready;
  assign w_load_ok = !r_out_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_load_ok) begin
      // A held skid entry always goes out first; in_ready was low, so nothing new arrives now.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_new;
      end
      r_in_ready <= 1'b1;
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) decode_cnt <= '0;
    else if (w_xfer) decode_cnt <= decode_cnt + 1'b1;
  end

  assign bus.in_ready    = (SKID != 0) ? r_in_ready : w_load_ok;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_opcode  = r_out.opcode;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_funct3  = r_out.funct3;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_rs2     = r_out.rs2;
  assign bus.out_funct7  = r_out.funct7;
  assign bus.out_fmt     = r_out.fmt;
  assign bus.out_imm     = XLEN'($signed(r_out.imm));
  assign bus.out_illegal = r_out.illegal;
endmodule
